// File: rtl/icache_pkg.sv
// Shared constants and FSM state encoding for the instruction-cache refill
// writer.
//
// Ports: none (package).
//   MEM_ADDR_WIDTH  backing-memory word-address width
//   ADDR_WIDTH      data-array address width, {set, word_off}
//   WORD_WIDTH      instruction word width
//   NUM_BLOCKS      number of ways (one-hot way mask width)
//   LINE_WORDS      words per line, power of two
//   OFF_BITS        log2(LINE_WORDS)
//   CNT_WIDTH       width of the beats-remaining down-counter
package icache_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int ADDR_WIDTH     = 8;
  localparam int WORD_WIDTH     = 20;
  localparam int NUM_BLOCKS     = 4;
  localparam int LINE_WORDS     = 4;
  localparam int OFF_BITS       = $clog2(LINE_WORDS);
  localparam int CNT_WIDTH      = OFF_BITS + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    DRAIN,
    DONE
  } refill_state_e;

endpackage

// File: rtl/icache_refill_writer_if.sv
// Bus bundle between the refill writer and its environment (miss source,
// backing memory, data-array write port).
//
// Modports:
//   master  the refill writer itself
//   slave   the environment driving misses, memory responses and array ready
interface icache_refill_writer_if;
  import icache_pkg::*;

  logic [MEM_ADDR_WIDTH-1:0] i_miss_addr;
  logic [NUM_BLOCKS-1:0]     i_miss_way;
  logic                      i_miss_valid;
  logic                      o_miss_ready;

  logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
  logic                      o_mem_req_valid;
  logic                      i_mem_req_ready;

  logic [WORD_WIDTH-1:0]     i_mem_rsp_data;
  logic                      i_mem_rsp_valid;
  logic                      o_mem_rsp_ready;

  logic [ADDR_WIDTH-1:0]     o_w_addr;
  logic [WORD_WIDTH-1:0]     o_w_data;
  logic                      o_w_valid;
  logic [NUM_BLOCKS-1:0]     o_w_mask;
  logic                      i_arr_ready;
  logic                      o_stop_write_clk;

  logic [WORD_WIDTH-1:0]     o_fwd_data;
  logic                      o_fwd_valid;

  logic                      o_busy;
  logic                      o_fill_done;

  modport master (
    input  i_miss_addr, i_miss_way, i_miss_valid,
    output o_miss_ready,
    output o_mem_addr, o_mem_req_valid,
    input  i_mem_req_ready,
    input  i_mem_rsp_data, i_mem_rsp_valid,
    output o_mem_rsp_ready,
    output o_w_addr, o_w_data, o_w_valid, o_w_mask, o_stop_write_clk,
    input  i_arr_ready,
    output o_fwd_data, o_fwd_valid,
    output o_busy, o_fill_done
  );

  modport slave (
    output i_miss_addr, i_miss_way, i_miss_valid,
    input  o_miss_ready,
    input  o_mem_addr, o_mem_req_valid,
    output i_mem_req_ready,
    output i_mem_rsp_data, i_mem_rsp_valid,
    input  o_mem_rsp_ready,
    input  o_w_addr, o_w_data, o_w_valid, o_w_mask, o_stop_write_clk,
    output i_arr_ready,
    input  o_fwd_data, o_fwd_valid,
    input  o_busy, o_fill_done
  );

endinterface

// File: rtl/refill_write_reg.sv
// One-entry registered write stage in front of the data-array write port.
//
// Ports:
//   clk, arst              clock, async active-high reset
//   load, load_addr/data/mask  new beat to capture
//   arr_ready              array accepts the held write this cycle
//   room                   a beat may be loaded this cycle
//   w_valid/addr/data/mask held write presented to the array
module refill_write_reg
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic [NUM_BLOCKS-1:0] load_mask,
  input  logic                  arr_ready,
  output logic                  room,
  output logic                  w_valid,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [WORD_WIDTH-1:0] w_data,
  output logic [NUM_BLOCKS-1:0] w_mask
);

  // A held write that the array is taking this cycle frees the slot, so a
  // new beat can overwrite it in the same cycle.
  assign room = ~w_valid | arr_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      w_valid <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
      w_mask  <= '0;
    end else if (load) begin
      w_valid <= 1'b1;
      w_addr  <= load_addr;
      w_data  <= load_data;
      w_mask  <= load_mask;
    end else if (arr_ready) begin
      w_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/icache_refill_writer.sv
// Instruction-cache refill writer: takes one miss, issues a single burst read,
// and writes the returned LINE_WORDS beats into the victim way through a
// one-entry write register, gating the array write clock while idle.
//
// Ports:
//   clk   single clock
//   arst  asynchronous active-high reset
//   bus   icache_refill_writer_if.master: miss handshake, memory request and
//         response, array write port, critical-word forward, status
//
// Build option: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN requests the missing word
// first (wrap order) and forwards the first beat on o_fwd_*. Without it the
// burst starts at offset 0 and o_fwd_* are tied to 0.
//
// state | meaning
// IDLE  | waiting for a miss, o_miss_ready high
// REQ   | burst request presented to memory
// FILL  | accepting response beats into the write register
// DRAIN | last beat accepted, waiting for the write register to empty
// DONE  | one-cycle o_fill_done pulse
module icache_refill_writer
  import icache_pkg::*;
(
  input  logic                   clk,
  input  logic                   arst,
  icache_refill_writer_if.master bus
);

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF_EN = 1'b1;
`else
  localparam bit CWF_EN = 1'b0;
`endif

  refill_state_e             state;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [NUM_BLOCKS-1:0]     way;
  logic [OFF_BITS-1:0]       off;
  logic [CNT_WIDTH-1:0]      beats_left;
  logic                      miss_ready;
  logic                      mem_req_valid;
  logic                      busy;
  logic                      fill_done;
  logic [OFF_BITS-1:0]       start_off;
  logic                      beat_acc;
  logic                      w_room;
  logic                      w_valid;
  logic [ADDR_WIDTH-1:0]     w_addr;
  logic [WORD_WIDTH-1:0]     w_data;
  logic [NUM_BLOCKS-1:0]     w_mask;
  logic                      fwd_valid;
  logic [WORD_WIDTH-1:0]     fwd_data;

  assign start_off = CWF_EN ? bus.i_miss_addr[OFF_BITS-1:0] : '0;
  assign beat_acc  = (state == FILL) & bus.i_mem_rsp_valid & w_room;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state         <= IDLE;
      mem_addr      <= '0;
      way           <= '0;
      off           <= '0;
      beats_left    <= '0;
      miss_ready    <= 1'b1;
      mem_req_valid <= 1'b0;
      busy          <= 1'b0;
      fill_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_miss_valid) begin
            mem_addr      <= {bus.i_miss_addr[MEM_ADDR_WIDTH-1:OFF_BITS], start_off};
            way           <= bus.i_miss_way;
            miss_ready    <= 1'b0;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.i_mem_req_ready) begin
            mem_req_valid <= 1'b0;
            off           <= mem_addr[OFF_BITS-1:0];
            beats_left    <= CNT_WIDTH'(LINE_WORDS);
            state         <= FILL;
          end
        end
        FILL: begin
          if (beat_acc) begin
            off        <= off + 1'b1;
            beats_left <= beats_left - 1'b1;
            if (beats_left == CNT_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!w_valid || bus.i_arr_ready) begin
            fill_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          fill_done  <= 1'b0;
          busy       <= 1'b0;
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          fill_done     <= 1'b0;
          mem_req_valid <= 1'b0;
          busy          <= 1'b0;
          miss_ready    <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  refill_write_reg u_write_reg (
    .clk       (clk),
    .arst      (arst),
    .load      (beat_acc),
    .load_addr ({mem_addr[ADDR_WIDTH-1:OFF_BITS], off}),
    .load_data (bus.i_mem_rsp_data),
    .load_mask (way),
    .arr_ready (bus.i_arr_ready),
    .room      (w_room),
    .w_valid   (w_valid),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_mask    (w_mask)
  );

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  // First beat of the burst is the missing word; present it alongside its
  // array write.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end else if (beat_acc && (beats_left == CNT_WIDTH'(LINE_WORDS))) begin
      fwd_valid <= 1'b1;
      fwd_data  <= bus.i_mem_rsp_data;
    end else begin
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

  assign bus.o_miss_ready     = miss_ready;
  assign bus.o_mem_addr       = mem_addr;
  assign bus.o_mem_req_valid  = mem_req_valid;
  assign bus.o_mem_rsp_ready  = (state == FILL) & w_room;
  assign bus.o_w_addr         = w_addr;
  assign bus.o_w_data         = w_data;
  assign bus.o_w_valid        = w_valid;
  assign bus.o_w_mask         = w_mask;
  assign bus.o_stop_write_clk = ~w_valid;
  assign bus.o_fwd_valid      = fwd_valid;
  assign bus.o_fwd_data       = fwd_data;
  assign bus.o_busy           = busy;
  assign bus.o_fill_done      = fill_done;

endmodule

// File: tb/tb_icache_refill_writer.sv
// Directed bench for icache_refill_writer. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. The memory model
// answers with one idle cycle after accepting the burst request, then one
// beat per cycle; beat data is {4'hC, word address}.
module tb_icache_refill_writer;
  import icache_pkg::*;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk;
  logic arst;
  int   cyc = 0;

  icache_refill_writer_if bus();

  icache_refill_writer dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // results of the most recent run_fill
  logic [31:0] wlog[$];
  int          done_at, m_cyc, first_req, req_cycles, bad_addr, early_acc;
  int          stall_bad, fwd_cnt, fwd_cyc, first_w_cyc;
  logic [19:0] fwd_dat;
  logic [15:0] req_addr_seen;
  bit          aborted;

  task automatic idle_inputs();
    bus.i_miss_addr     = '0;
    bus.i_miss_way      = '0;
    bus.i_miss_valid    = 1'b0;
    bus.i_mem_req_ready = 1'b0;
    bus.i_mem_rsp_data  = '0;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_arr_ready     = 1'b1;
  endtask

  // One complete miss. req_hold: cycles of request backpressure; stall_beat /
  // stall_len: array stall after that beat is accepted; rst_beat: assert arst
  // while that beat sits in the write register; stray: drive junk response
  // beats before the request is accepted.
  task automatic run_fill(input string tag, input logic [15:0] addr, input logic [3:0] way,
                          input int req_hold, input int stall_beat, input int stall_len,
                          input int rst_beat, input bit stray);
    int          beats, stall_left, r;
    bit          req_done, missed, acc_now;
    logic [15:0] mem_start;
    logic [1:0]  bo;
    wlog.delete();
    done_at = -1; m_cyc = -1; first_req = -1; req_cycles = 0; bad_addr = 0;
    early_acc = 0; stall_bad = 0; fwd_cnt = 0; fwd_cyc = -1; first_w_cyc = -1;
    fwd_dat = '0; req_addr_seen = '0; aborted = 1'b0;
    beats = 0; stall_left = 0; r = 0; req_done = 1'b0; missed = 1'b0;
    mem_start = CWF ? addr : {addr[15:2], 2'b00};
    for (int n = 0; n < 80; n++) begin
      bus.i_miss_addr     = addr;
      bus.i_miss_way      = way;
      bus.i_miss_valid    = !missed;
      bus.i_mem_req_ready = (req_cycles >= req_hold);
      bo = mem_start[1:0] + beats[1:0];
      if (req_done && cyc >= r + 2 && beats < LINE_WORDS) begin
        bus.i_mem_rsp_valid = 1'b1;
        bus.i_mem_rsp_data  = {4'hC, addr[15:2], bo};
      end else if (stray && !req_done) begin
        bus.i_mem_rsp_valid = 1'b1;
        bus.i_mem_rsp_data  = 20'hFFFFF;
      end else begin
        bus.i_mem_rsp_valid = 1'b0;
        bus.i_mem_rsp_data  = '0;
      end
      bus.i_arr_ready = (stall_left == 0);
      @(negedge clk);
      if (rst_beat > 0 && beats == rst_beat) begin
        check_eq({tag, "_pre_w_valid"}, bus.o_w_valid, 1);
        arst = 1'b1;
        #1;
        check_eq({tag, "_w_valid"}, bus.o_w_valid, 0);
        check_eq({tag, "_busy"}, bus.o_busy, 0);
        check_eq({tag, "_stop_wclk"}, bus.o_stop_write_clk, 1);
        check_eq({tag, "_rsp_ready"}, bus.o_mem_rsp_ready, 0);
        check_eq({tag, "_req_valid"}, bus.o_mem_req_valid, 0);
        check_eq({tag, "_miss_ready"}, bus.o_miss_ready, 1);
        aborted = 1'b1;
        break;
      end
      if (!missed && bus.i_miss_valid && bus.o_miss_ready) begin
        missed = 1'b1;
        m_cyc  = cyc;
      end
      acc_now = bus.i_mem_rsp_valid && bus.o_mem_rsp_ready;
      if (acc_now && !req_done) early_acc++;
      else if (acc_now) beats++;
      if (stall_left > 0) begin
        if (bus.o_mem_rsp_ready) stall_bad++;
        stall_left--;
      end else if (acc_now && req_done && stall_beat > 0 && beats == stall_beat) begin
        stall_left = stall_len;
      end
      if (bus.o_mem_req_valid) begin
        if (first_req < 0) begin
          first_req     = cyc;
          req_addr_seen = bus.o_mem_addr;
        end
        if (bus.o_mem_addr !== req_addr_seen) bad_addr++;
        req_cycles++;
        if (bus.i_mem_req_ready) begin
          req_done = 1'b1;
          r        = cyc;
        end
      end
      if (bus.o_w_valid && first_w_cyc < 0) first_w_cyc = cyc;
      if (bus.o_w_valid && bus.i_arr_ready) wlog.push_back({bus.o_w_addr, bus.o_w_data, bus.o_w_mask});
      if (bus.o_fwd_valid) begin
        fwd_cnt++;
        fwd_cyc = cyc;
        fwd_dat = bus.o_fwd_data;
      end
      if (bus.o_fill_done) done_at = cyc;
      @(posedge clk);
      #1;
      if (done_at >= 0) break;
    end
    idle_inputs();
    if (!aborted) begin
      check_eq({tag, "_completes"}, done_at >= 0, 1);
      @(negedge clk);
      check_eq({tag, "_miss_ready_after"}, bus.o_miss_ready, 1);
      check_eq({tag, "_done_pulse_end"}, bus.o_fill_done, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_writes(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3, input logic [3:0] way);
    logic [7:0] a;
    check_eq({tag, "_write_count"}, wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? a0 : (i == 1) ? a1 : (i == 2) ? a2 : a3;
      if (i < wlog.size())
        check_eq($sformatf("%s_write%0d", tag, i), wlog[i], {a, 4'hC, 8'h12, a, way});
    end
  endtask

  int bad;

  initial begin
    idle_inputs();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_miss_ready", bus.o_miss_ready, 1);
    check_eq("rst_stop_wclk", bus.o_stop_write_clk, 1);
    check_eq("rst_req_valid", bus.o_mem_req_valid, 0);
    check_eq("rst_mem_addr", bus.o_mem_addr, 0);
    check_eq("rst_rsp_ready", bus.o_mem_rsp_ready, 0);
    check_eq("rst_w_valid", bus.o_w_valid, 0);
    check_eq("rst_w_addr", bus.o_w_addr, 0);
    check_eq("rst_w_mask", bus.o_w_mask, 0);
    check_eq("rst_fwd_valid", bus.o_fwd_valid, 0);
    check_eq("rst_busy", bus.o_busy, 0);
    check_eq("rst_fill_done", bus.o_fill_done, 0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // stray response while idle
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rsp_data  = 20'h5A5A5;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_mem_rsp_ready || bus.o_w_valid || bus.o_busy) bad++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check_eq("stray_idle", bad, 0);

    // plain fill
    run_fill("plain", 16'h1234, 4'b0010, 0, 0, 0, 0, 1'b0);
    check_writes("plain", 8'h34, 8'h35, 8'h36, 8'h37, 4'b0010);
    check_eq("plain_done_lat", done_at - m_cyc, 8);
    check_eq("plain_req_lat", first_req - m_cyc, 1);
    check_eq("plain_mem_addr", req_addr_seen, 16'h1234);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    check_eq("plain_fwd_cnt", fwd_cnt, 1);
    check_eq("plain_fwd_data", fwd_dat, 20'hC1234);
`else
    check_eq("plain_fwd_cnt", fwd_cnt, 0);
`endif

    // array stall of 3 cycles with beat 2 held in the write register
    run_fill("stall", 16'h1250, 4'b1000, 0, 2, 3, 0, 1'b0);
    check_writes("stall", 8'h50, 8'h51, 8'h52, 8'h53, 4'b1000);
    check_eq("stall_rsp_ready_low", stall_bad, 0);
    check_eq("stall_done_lat", done_at - m_cyc, 11);

    // memory request backpressure with junk beats offered meanwhile
    run_fill("reqbp", 16'h12A8, 4'b0001, 5, 0, 0, 0, 1'b1);
    check_eq("reqbp_addr_stable", bad_addr, 0);
    check_eq("reqbp_req_cycles", req_cycles, 6);
    check_eq("reqbp_early_accept", early_acc, 0);
    check_eq("reqbp_mem_addr", req_addr_seen, 16'h12A8);
    check_eq("reqbp_done_lat", done_at - m_cyc, 13);
    check_writes("reqbp", 8'hA8, 8'hA9, 8'hAA, 8'hAB, 4'b0001);

    // reset with beat 2 pending, then a clean fill
    run_fill("midrst", 16'h12C4, 4'b0100, 0, 0, 0, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    run_fill("after_rst", 16'h12E0, 4'b0100, 0, 0, 0, 0, 1'b0);
    check_writes("after_rst", 8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'b0100);
    check_eq("after_rst_done_lat", done_at - m_cyc, 8);

    // miss in the middle of a line
    run_fill("cwf", 16'h1236, 4'b0010, 0, 0, 0, 0, 1'b0);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    check_eq("cwf_mem_addr", req_addr_seen, 16'h1236);
    check_writes("cwf", 8'h36, 8'h37, 8'h34, 8'h35, 4'b0010);
    check_eq("cwf_fwd_cnt", fwd_cnt, 1);
    check_eq("cwf_fwd_data", fwd_dat, 20'hC1236);
    check_eq("cwf_fwd_cycle", fwd_cyc, first_w_cyc);
`else
    check_eq("cwf_mem_addr", req_addr_seen, 16'h1234);
    check_writes("cwf", 8'h34, 8'h35, 8'h36, 8'h37, 4'b0010);
    check_eq("cwf_fwd_cnt", fwd_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_refill_writer.md
# icache_refill_writer

Refill stage sitting directly upstream of the data arrays container's write port. On a cache miss it accepts one line-fill request, issues a single burst read to backing memory, and collects LINE_WORDS response beats. Each beat is written into the selected way's SRAM through a one-entry registered write stage that respects the arrays' `o_ready` stall. It also drives the arrays' write-clock gate so the write SRAMs clock only while a beat is being written.

## Interface
- `MEM_ADDR_WIDTH`, 16: memory word-address width.
- `ADDR_WIDTH`, 8: data-array address width, `{set[5:0], word_off[1:0]}`.
- `WORD_WIDTH`, 20: instruction word width.
- `NUM_BLOCKS`, 4: ways; one-hot way mask width.
- `LINE_WORDS`, 4: words per line, power of two; `OFF_BITS = log2(LINE_WORDS)`.

- `clk` in 1: single clock.
- `arst` in 1: asynchronous, active-high reset.
- `i_miss_addr` in MEM_ADDR_WIDTH: word address of the missing fetch.
- `i_miss_way` in NUM_BLOCKS: one-hot victim way.
- `i_miss_valid` in 1 / `o_miss_ready` out 1: miss request handshake.
- `o_mem_addr` out MEM_ADDR_WIDTH: burst start address.
- `o_mem_req_valid` out 1 / `i_mem_req_ready` in 1: memory request handshake.
- `i_mem_rsp_data` in WORD_WIDTH, `i_mem_rsp_valid` in 1 / `o_mem_rsp_ready` out 1: response beats.
- `o_w_addr` out ADDR_WIDTH, `o_w_data` out WORD_WIDTH, `o_w_valid` out 1, `o_w_mask` out NUM_BLOCKS: to the array write port.
- `i_arr_ready` in 1: the arrays' `o_ready`.
- `o_stop_write_clk` out 1: to the arrays' `i_stop_write_clk`.
- `o_fwd_data` out WORD_WIDTH, `o_fwd_valid` out 1: critical-word forward.
- `o_busy` out 1, `o_fill_done` out 1: status; `o_fill_done` is a one-cycle pulse.

## Operation
- States: IDLE, REQ, FILL, DRAIN, DONE. Reset enters IDLE.
- IDLE:
  - `o_miss_ready=1`.
  - On `i_miss_valid`, latch the address, way and start offset, then go to REQ.
- REQ:
  - `o_mem_req_valid=1`, with `o_mem_addr = {addr[MSB:OFF_BITS], start_off}`.
  - Hold until `i_mem_req_ready`, then go to FILL.
  - Clear the beat count and set the offset counter to `start_off`.
- FILL:
  - `o_mem_rsp_ready = ~w_valid | i_arr_ready`.
  - An accepted beat loads the write register: `o_w_addr = {addr[ADDR_WIDTH-1:OFF_BITS], off}`, `o_w_mask = way`.
  - Each accepted beat increments the offset (wraps modulo LINE_WORDS) and the beat count.
  - After beat LINE_WORDS is accepted, go to DRAIN.
- DRAIN: when the write register is empty, or drains this cycle, go to DONE.
- DONE: `o_fill_done=1` for one cycle, then go to IDLE.
- Write register:
  - Set by an accepted beat; cleared when `i_arr_ready=1` and no new beat loads.
  - Writes are never dropped while `i_arr_ready=0`.
- Outputs:
  - `o_stop_write_clk = ~o_w_valid`.
  - `o_busy = (state != IDLE)`.
  - `o_mem_rsp_ready = 0` outside FILL; beats arriving outside FILL are not accepted.
- Reset mid-operation: return to IDLE immediately, discard any pending write and drop all handshakes. The partially filled line remains un-validated (tag logic is not written).

## Timing
- Reset values: all outputs 0, except `o_stop_write_clk=1` and `o_miss_ready=1`.
- Latency:
  - Miss accepted at edge 0 → `o_mem_req_valid` in cycle 1.
  - Beat accepted at edge k → `o_w_valid` in cycle k+1.
  - Last write drained at edge d → `o_fill_done` in cycle d+1; `o_miss_ready` in cycle d+2.
- With no stalls, a fill takes LINE_WORDS+4 cycles from miss acceptance to `o_fill_done`.
- Back-to-back beats are sustained at one per cycle while `i_arr_ready=1`.
- Simultaneous drain and load: the register is overwritten with the new beat and stays valid.

## Configuration
- `ICACHE_REFILL_CRITICAL_WORD_FIRST_EN` defined:
  - `start_off = i_miss_addr[OFF_BITS-1:0]`; memory returns words in wrap order from that offset.
  - The first accepted beat also drives `o_fwd_valid=1` and `o_fwd_data` for one cycle, the same cycle as its `o_w_valid`.
- Not defined:
  - `start_off = 0`.
  - `o_fwd_valid` and `o_fwd_data` are tied to 0.

## Structure
- Shared package `icache_pkg`:
  - width constants (`ADDR_WIDTH`, `WORD_WIDTH`, `NUM_BLOCKS`, `LINE_WORDS`, `OFF_BITS`, `MEM_ADDR_WIDTH`);
  - FSM state encoding.
- One sub-module `refill_write_reg`: the one-entry write register with load/drain handshake.

## Test plan
- Plain fill:
  - Stimulus: miss addr 0x1234, way 4'b0010, no stalls.
  - Required: writes to addresses 0x34, 0x35, 0x36, 0x37 with mask 0010; `o_fill_done` 8 cycles after miss acceptance.
- Array stall:
  - Stimulus: hold `i_arr_ready=0` for 3 cycles during beat 2.
  - Required: `o_mem_rsp_ready=0` during the stall; all 4 writes occur in order with no loss.
- Memory request backpressure:
  - Stimulus: `i_mem_req_ready=0` for 5 cycles.
  - Required: `o_mem_req_valid` and `o_mem_addr` held stable; no beats accepted.
- Mid-fill reset:
  - Stimulus: assert `arst` after beat 2.
  - Required: immediately `o_w_valid=0`, `o_busy=0`, `o_stop_write_clk=1`; a new miss afterwards completes normally.
- With the macro:
  - Stimulus: miss addr 0x1236.
  - Required: `o_mem_addr=0x1236`; writes at 0x36, 0x37, 0x34, 0x35; `o_fwd_valid` pulses with the first beat's data.
- Stray response:
  - Stimulus: `i_mem_rsp_valid=1` while IDLE.
  - Required: `o_mem_rsp_ready=0`; no array write.
